// File: rtl/axi_mem_sram.sv
// Byte-enabled synchronous 64-bit RAM with registered read data.
// The storage array is named mem so a bench can preload it hierarchically.
module axi_mem_sram #(
    parameter int unsigned Depth     = 8192,
    parameter int unsigned AddrWidth = 13,
    parameter string       INIT_FILE = ""
) (
    input  logic                 clk,
    input  logic [7:0]           we,
    input  logic [AddrWidth-1:0] addr,
    input  logic [63:0]          din,
    output logic [63:0]          dout
);

    logic [63:0] mem [Depth];

    // Read-during-write returns the old word; the wrapper never needs both at once.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 8; b++) begin
            if (we[b]) begin
                mem[addr][b*8 +: 8] <= din[b*8 +: 8];
            end
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/axi_mem_wrap.sv
// Single-port AXI4 slave memory: serves one read or write burst at a time,
// 64-bit data path, addresses alias modulo MEM_SIZE, always responds OKAY.
module axi_mem_wrap #(
    parameter int unsigned ID_WIDTH  = 2,
    parameter int unsigned MEM_SIZE  = 32'h10000,
    parameter string       INIT_FILE = ""
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ID_WIDTH-1:0] i_awid,
    input  logic [31:0]         i_awaddr,
    input  logic [7:0]          i_awlen,
    input  logic [2:0]          i_awsize,
    input  logic [1:0]          i_awburst,
    input  logic                i_awvalid,
    output logic                o_awready,
    input  logic [ID_WIDTH-1:0] i_arid,
    input  logic [31:0]         i_araddr,
    input  logic [7:0]          i_arlen,
    input  logic [2:0]          i_arsize,
    input  logic [1:0]          i_arburst,
    input  logic                i_arvalid,
    output logic                o_arready,
    input  logic [63:0]         i_wdata,
    input  logic [7:0]          i_wstrb,
    input  logic                i_wlast,
    input  logic                i_wvalid,
    output logic                o_wready,
    output logic [ID_WIDTH-1:0] o_bid,
    output logic [1:0]          o_bresp,
    output logic                o_bvalid,
    input  logic                i_bready,
    output logic [ID_WIDTH-1:0] o_rid,
    output logic [63:0]         o_rdata,
    output logic [1:0]          o_rresp,
    output logic                o_rlast,
    output logic                o_rvalid,
    input  logic                i_rready
);

    localparam int unsigned Depth  = MEM_SIZE / 8;
    localparam int unsigned WordAw = (Depth > 1) ? $clog2(Depth) : 1;

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstWrap  = 2'b10;
    localparam logic [1:0] RespOkay   = 2'b00;

    typedef enum logic [2:0] {
        StIdle,
        StWdata,
        StWresp,
        StRread,
        StRdata
    } state_e;

    state_e              state_q, state_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [31:0]         addr_q, addr_d;
    logic [7:0]          len_q, len_d;
    logic [2:0]          size_q, size_d;
    logic [1:0]          burst_q, burst_d;
    logic [7:0]          beat_q, beat_d;

    logic [7:0]          ram_we;
    logic [WordAw-1:0]   ram_addr;
    logic [63:0]         ram_dout;
    logic                last_beat;
    logic                unused_wlast;

    // The beat counter decides the end of a write burst, so wlast carries no information.
    assign unused_wlast = i_wlast;

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] incr;
        logic [31:0] mask;
        logic        wrap_ok;
        incr    = 32'd1 << size;
        wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        mask    = (({24'd0, len} + 32'd1) << size) - 32'd1;
        if (burst == BurstFixed) begin
            return addr;
        end else if ((burst == BurstWrap) && wrap_ok) begin
            return (addr & ~mask) | ((addr + incr) & mask);
        end
        return addr + incr;
    endfunction

    // Masking keeps the index in range and makes out-of-range addresses alias.
    assign ram_addr  = WordAw'(addr_q >> 3) & WordAw'(Depth - 1);
    assign last_beat = (beat_q == len_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        beat_d    = beat_q;
        ram_we    = '0;
        o_awready = 1'b0;
        o_arready = 1'b0;
        o_wready  = 1'b0;
        o_bvalid  = 1'b0;
        o_rvalid  = 1'b0;
        o_rlast   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Ready outputs are held low while reset is asserted.
                o_awready = rst_n;
                o_arready = rst_n && !i_awvalid;
                if (i_awvalid) begin
                    id_d    = i_awid;
                    addr_d  = i_awaddr;
                    len_d   = i_awlen;
                    size_d  = i_awsize;
                    burst_d = i_awburst;
                    beat_d  = '0;
                    state_d = StWdata;
                end else if (i_arvalid) begin
                    id_d    = i_arid;
                    addr_d  = i_araddr;
                    len_d   = i_arlen;
                    size_d  = i_arsize;
                    burst_d = i_arburst;
                    beat_d  = '0;
                    state_d = StRread;
                end
            end
            StWdata: begin
                o_wready = 1'b1;
                if (i_wvalid) begin
                    ram_we = i_wstrb;
                    addr_d = next_addr(addr_q, len_q, size_q, burst_q);
                    if (last_beat) begin
                        state_d = StWresp;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            StWresp: begin
                o_bvalid = 1'b1;
                if (i_bready) begin
                    state_d = StIdle;
                end
            end
            StRread: begin
                state_d = StRdata;
            end
            StRdata: begin
                o_rvalid = 1'b1;
                o_rlast  = last_beat;
                if (i_rready) begin
                    if (last_beat) begin
                        state_d = StIdle;
                    end else begin
                        addr_d  = next_addr(addr_q, len_q, size_q, burst_q);
                        beat_d  = beat_q + 8'd1;
                        state_d = StRread;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Address and memory are untouched in StRdata, so the RAM output holds steady under stall.
    assign o_rdata = (state_q == StRdata) ? ram_dout : 64'd0;
    assign o_rid   = id_q;
    assign o_bid   = id_q;
    assign o_rresp = RespOkay;
    assign o_bresp = RespOkay;

    axi_mem_sram #(
        .Depth    (Depth),
        .AddrWidth(WordAw),
        .INIT_FILE(INIT_FILE)
    ) ram (
        .clk (clk),
        .we  (ram_we),
        .addr(ram_addr),
        .din (i_wdata),
        .dout(ram_dout)
    );

endmodule

// File: tb/tb_axi_mem_wrap.sv
// Randomized bench for axi_mem_wrap checked against a word-array memory model.
module tb_axi_mem_wrap;

    localparam int unsigned IDW   = 3;
    localparam int unsigned MEM   = 32'h1000;
    localparam int unsigned WORDS = MEM / 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [IDW-1:0] i_awid, i_arid;
    logic [31:0]    i_awaddr, i_araddr;
    logic [7:0]     i_awlen, i_arlen;
    logic [2:0]     i_awsize, i_arsize;
    logic [1:0]     i_awburst, i_arburst;
    logic           i_awvalid, i_arvalid, o_awready, o_arready;
    logic [63:0]    i_wdata;
    logic [7:0]     i_wstrb;
    logic           i_wlast, i_wvalid, o_wready;
    logic [IDW-1:0] o_bid, o_rid;
    logic [1:0]     o_bresp, o_rresp;
    logic           o_bvalid, i_bready;
    logic [63:0]    o_rdata;
    logic           o_rlast, o_rvalid, i_rready;

    always #5 clk = ~clk;

    axi_mem_wrap #(
        .ID_WIDTH (IDW),
        .MEM_SIZE (MEM),
        .INIT_FILE("")
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_awid   (i_awid),
        .i_awaddr (i_awaddr),
        .i_awlen  (i_awlen),
        .i_awsize (i_awsize),
        .i_awburst(i_awburst),
        .i_awvalid(i_awvalid),
        .o_awready(o_awready),
        .i_arid   (i_arid),
        .i_araddr (i_araddr),
        .i_arlen  (i_arlen),
        .i_arsize (i_arsize),
        .i_arburst(i_arburst),
        .i_arvalid(i_arvalid),
        .o_arready(o_arready),
        .i_wdata  (i_wdata),
        .i_wstrb  (i_wstrb),
        .i_wlast  (i_wlast),
        .i_wvalid (i_wvalid),
        .o_wready (o_wready),
        .o_bid    (o_bid),
        .o_bresp  (o_bresp),
        .o_bvalid (o_bvalid),
        .i_bready (i_bready),
        .o_rid    (o_rid),
        .o_rdata  (o_rdata),
        .o_rresp  (o_rresp),
        .o_rlast  (o_rlast),
        .o_rvalid (o_rvalid),
        .i_rready (i_rready)
    );

    typedef struct packed {
        logic [63:0]    data;
        logic           last;
        logic [IDW-1:0] id;
    } rbeat_t;

    int             n_vec = 0;
    int             n_err = 0;
    logic [63:0]    mdl [WORDS];
    rbeat_t         r_exp[$];
    logic [63:0]    got[$];
    logic [63:0]    wd_q[$];
    logic [7:0]     ws_q[$];
    logic           b_pend = 1'b0;
    logic [IDW-1:0] b_id_exp = '0;
    logic           wlast_flip = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic void tmo(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: no handshake within cycle budget", name);
    endfunction

    // Byte address of beat n, straight from the burst rules.
    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int unsigned n,
                                              input logic [7:0] len, input logic [2:0] size,
                                              input logic [1:0] burst);
        int unsigned incr;
        int unsigned win;
        int unsigned base;
        incr = 1 << size;
        win  = (int'(len) + 1) * incr;
        if (burst == 2'b00) return start;
        if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            base = start - (start % win);
            return base + ((start - base + n * incr) % win);
        end
        return start + n * incr;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a / 8) % WORDS);
    endfunction

    // Per-cycle compare of every DUT output against the bench's expectations.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_awready", o_awready, 0);
            chk("rst_arready", o_arready, 0);
            chk("rst_wready", o_wready, 0);
            chk("rst_bvalid", o_bvalid, 0);
            chk("rst_rvalid", o_rvalid, 0);
            chk("rst_rlast", o_rlast, 0);
            chk("rst_ids", {o_bid, o_rid}, 0);
            chk("rst_resp", {o_bresp, o_rresp}, 0);
            chk("rst_rdata", o_rdata, 0);
        end else begin
            chk("bvalid", o_bvalid, b_pend);
            if (o_bvalid) begin
                chk("bid", o_bid, b_id_exp);
                chk("bresp", o_bresp, 2'b00);
            end
            if (o_rvalid) begin
                if (r_exp.size() == 0) begin
                    chk("rvalid_unexpected", o_rvalid, 0);
                end else begin
                    chk("rdata", o_rdata, r_exp[0].data);
                    chk("rid", o_rid, r_exp[0].id);
                    chk("rlast", o_rlast, r_exp[0].last);
                    chk("rresp", o_rresp, 2'b00);
                    if (i_rready) void'(r_exp.pop_front());
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_wready", o_wready, 0);
        chk("abort_bvalid", o_bvalid, 0);
        chk("abort_rvalid", o_rvalid, 0);
        chk("abort_awready", o_awready, 0);
        b_pend = 1'b0;
        r_exp.delete();
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [IDW-1:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input int bstall, input int abort_at);
        bit hs;
        int t;
        int w;
        logic [31:0] ba;
        i_awid = id; i_awaddr = addr; i_awlen = len; i_awsize = size; i_awburst = burst;
        i_awvalid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            hs = o_awready;
            if (hs && i_arvalid) chk("ar_blocked_by_aw", o_arready, 0);
            @(posedge clk);
            #1;
            t++;
        end while (!hs && t < 200);
        i_awvalid = 1'b0;
        if (!hs) begin
            tmo("aw_handshake");
            return;
        end
        for (int n = 0; n <= int'(len); n++) begin
            if ($urandom_range(0, 3) == 0) begin
                i_wvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            i_wdata  = wd_q[n];
            i_wstrb  = ws_q[n];
            i_wlast  = (n == int'(len)) ^ wlast_flip;
            i_wvalid = 1'b1;
            t = 0;
            do begin
                @(negedge clk);
                hs = o_wready;
                @(posedge clk);
                #1;
                t++;
            end while (!hs && t < 200);
            if (!hs) begin
                i_wvalid = 1'b0;
                tmo("w_handshake");
                return;
            end
            ba = beat_addr(addr, n, len, size, burst);
            w  = widx(ba);
            for (int b = 0; b < 8; b++) if (ws_q[n][b]) mdl[w][b*8 +: 8] = wd_q[n][b*8 +: 8];
            if (n + 1 == abort_at) begin
                i_wvalid = 1'b0;
                do_reset();
                return;
            end
        end
        i_wvalid = 1'b0;
        i_wlast  = 1'b0;
        b_pend   = 1'b1;
        b_id_exp = id;
        i_bready = 1'b0;
        for (int s = 0; s < bstall; s++) begin
            @(negedge clk);
            chk("bvalid_held", o_bvalid, 1);
            @(posedge clk);
            #1;
        end
        i_bready = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            hs = o_bvalid;
            @(posedge clk);
            #1;
            t++;
        end while (!hs && t < 200);
        i_bready = 1'b0;
        b_pend   = 1'b0;
        if (!hs) tmo("b_handshake");
    endtask

    task automatic axi_read(input logic [IDW-1:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input int stall_beat, input int stall_cyc,
                            input int abort_at);
        bit hs;
        int t;
        int stall;
        rbeat_t e;
        i_arid = id; i_araddr = addr; i_arlen = len; i_arsize = size; i_arburst = burst;
        i_arvalid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            hs = o_arready;
            @(posedge clk);
            #1;
            t++;
        end while (!hs && t < 200);
        i_arvalid = 1'b0;
        got.delete();
        if (!hs) begin
            tmo("ar_handshake");
            return;
        end
        for (int n = 0; n <= int'(len); n++) begin
            e.data = mdl[widx(beat_addr(addr, n, len, size, burst))];
            e.last = (n == int'(len));
            e.id   = id;
            r_exp.push_back(e);
        end
        for (int n = 0; n <= int'(len); n++) begin
            @(negedge clk);
            chk("rvalid_gap", o_rvalid, 0);
            @(posedge clk);
            #1;
            if (n == abort_at) begin
                @(negedge clk);
                chk("rvalid_before_abort", o_rvalid, 1);
                do_reset();
                return;
            end
            stall = (n == stall_beat) ? stall_cyc : int'($urandom_range(0, 1));
            i_rready = (stall == 0);
            t = 0;
            do begin
                @(negedge clk);
                hs = o_rvalid && i_rready;
                if (t == 0) chk("rvalid_latency", o_rvalid, 1);
                if (hs) got.push_back(o_rdata);
                @(posedge clk);
                #1;
                t++;
                if (t >= stall) i_rready = 1'b1;
            end while (!hs && t < 200);
            i_rready = 1'b0;
            if (!hs) begin
                tmo("r_handshake");
                return;
            end
        end
        chk("r_queue_drained", r_exp.size(), 0);
    endtask

    task automatic fill(input int beats, input bit rnd, input logic [63:0] d0, input logic [7:0] s0);
        wd_q.delete();
        ws_q.delete();
        for (int i = 0; i < beats; i++) begin
            wd_q.push_back(rnd ? {$urandom, $urandom} : d0 + 64'(i));
            ws_q.push_back(rnd ? 8'($urandom_range(0, 255)) : s0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] v;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] addr;
        i_awid = '0; i_awaddr = '0; i_awlen = '0; i_awsize = '0; i_awburst = '0; i_awvalid = 0;
        i_arid = '0; i_araddr = '0; i_arlen = '0; i_arsize = '0; i_arburst = '0; i_arvalid = 0;
        i_wdata = '0; i_wstrb = '0; i_wlast = 0; i_wvalid = 0; i_bready = 0; i_rready = 0;
        for (int i = 0; i < int'(WORDS); i++) begin
            v = {$urandom, $urandom};
            dut.ram.mem[i] = v;
            mdl[i] = v;
        end
        dut.ram.mem[0] = 64'h7c029073aaaa02b7;
        mdl[0] = 64'h7c029073aaaa02b7;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_awready", o_awready, 1);
        chk("idle_arready", o_arready, 1);
        @(posedge clk);
        #1;

        // Preloaded single-beat read.
        axi_read(3'd5, 32'h0, 8'd0, 3'd3, 2'b01, -1, 0, -1);
        chk("preload_beats", got.size(), 1);
        chk("preload_data", got[0], 64'h7c029073aaaa02b7);
        @(negedge clk);
        chk("arready_after_read", o_arready, 1);
        @(posedge clk);
        #1;

        // INCR write then read back.
        fill(4, 0, 64'd1, 8'hFF);
        axi_write(3'd3, 32'h100, 8'd3, 3'd3, 2'b01, 0, -1);
        axi_read(3'd1, 32'h100, 8'd3, 3'd3, 2'b01, -1, 0, -1);
        chk("incr_beats", got.size(), 4);
        for (int i = 0; i < 4; i++) chk("incr_data", got[i], 64'(i + 1));

        // Byte strobes.
        fill(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        axi_write(3'd0, 32'h0, 8'd0, 3'd3, 2'b01, 0, -1);
        fill(1, 0, 64'h0, 8'h0F);
        axi_write(3'd0, 32'h0, 8'd0, 3'd3, 2'b01, 0, -1);
        axi_read(3'd0, 32'h0, 8'd0, 3'd3, 2'b01, -1, 0, -1);
        chk("strobe_data", got[0], 64'hFFFF_FFFF_0000_0000);

        // Simultaneous AW and AR: write wins, read sees written data.
        i_arid = 3'd2; i_araddr = 32'h100; i_arlen = 8'd0; i_arsize = 3'd3; i_arburst = 2'b01;
        i_arvalid = 1'b1;
        fill(1, 0, 64'hCAFE, 8'hFF);
        axi_write(3'd1, 32'h100, 8'd0, 3'd3, 2'b01, 0, -1);
        axi_read(3'd2, 32'h100, 8'd0, 3'd3, 2'b01, -1, 0, -1);
        chk("race_data", got[0], 64'hCAFE);

        // Backpressure on R and B.
        axi_read(3'd4, 32'h100, 8'd3, 3'd3, 2'b01, 1, 5, -1);
        chk("stall_beats", got.size(), 4);
        fill(2, 1, 64'h0, 8'h0);
        axi_write(3'd6, 32'h300, 8'd1, 3'd3, 2'b01, 4, -1);

        // WRAP read and aliasing.
        fill(4, 0, 64'hA0, 8'hFF);
        axi_write(3'd0, 32'h0, 8'd3, 3'd3, 2'b01, 0, -1);
        axi_read(3'd7, 32'h18, 8'd3, 3'd3, 2'b10, -1, 0, -1);
        chk("wrap_b0", got[0], 64'hA3);
        chk("wrap_b1", got[1], 64'hA0);
        chk("wrap_b2", got[2], 64'hA1);
        chk("wrap_b3", got[3], 64'hA2);
        axi_read(3'd0, MEM + 32'h8, 8'd0, 3'd3, 2'b01, -1, 0, -1);
        chk("alias_data", got[0], 64'hA1);

        // Reset mid-write keeps earlier beats; reset mid-read drops valids.
        fill(4, 1, 64'h0, 8'h0);
        axi_write(3'd2, 32'h200, 8'd3, 3'd3, 2'b01, 0, 2);
        axi_read(3'd2, 32'h200, 8'd3, 3'd3, 2'b01, -1, 0, -1);
        axi_read(3'd3, 32'h200, 8'd3, 3'd3, 2'b01, -1, 0, 1);

        // Randomized bursts.
        for (int it = 0; it < 40; it++) begin
            burst = 2'($urandom_range(0, 2));
            size  = 3'($urandom_range(0, 3));
            if (burst == 2'b10 && $urandom_range(0, 3) != 0) len = 8'((2 << $urandom_range(0, 3)) - 1);
            else len = 8'($urandom_range(0, 15));
            addr = $urandom_range(0, 2 * MEM - 1);
            addr = addr & ~((32'd1 << size) - 32'd1);
            wlast_flip = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 0) begin
                fill(int'(len) + 1, 1, 64'h0, 8'h0);
                axi_write(3'($urandom), addr, len, size, burst, int'($urandom_range(0, 2)), -1);
            end else begin
                axi_read(3'($urandom), addr, len, size, burst, int'($urandom_range(0, 15)),
                         int'($urandom_range(0, 3)), -1);
            end
        end
        wlast_flip = 1'b0;

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
